// File: rtl/logic_gate_pipe_pkg.sv
// Shared definitions for the registered logic-gate lane: operation codes.
package logic_gate_pipe_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage

// File: rtl/logic_gate_pipe_alu.sv
// Combinational op decode: bitwise result plus the op-dependent reduction bit.
module logic_gate_pipe_alu
  import logic_gate_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] y_o,
  output logic             red_o
);

  always_comb begin
    y_o   = '0;
    red_o = 1'b0;
    unique case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NAND: y_o = ~(a_i & b_i);
      OP_NOR:  y_o = ~(a_i | b_i);
      OP_XNOR: y_o = ~(a_i ^ b_i);
      OP_NOT:  y_o = ~a_i;
      OP_PASS: y_o = a_i;
    endcase
    // Reduction follows the family of the op: AND-like, XOR-like, else OR.
    unique case (op_i)
      OP_AND, OP_NAND: red_o = &y_o;
      OP_XOR, OP_XNOR: red_o = ^y_o;
      OP_OR, OP_NOR, OP_NOT, OP_PASS: red_o = |y_o;
    endcase
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Registered logic lane: one-stage valid/ready register around the op decode,
// with zero flag, reduction bit and a wrapping output-handshake counter.
module logic_gate_pipe
  import logic_gate_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             red,
  output logic [CNT_W-1:0] txn_count
);

  logic [WIDTH-1:0] y_c;
  logic             red_c;
  logic             in_fire, out_fire;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             red_q, red_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic_gate_pipe_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a_i  (a),
    .b_i  (b),
    .op_i (op_e'(op)),
    .y_o  (y_c),
    .red_o(red_c)
  );

  assign in_ready = !valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = valid_q && out_ready;

  always_comb begin
    valid_d = valid_q;
    y_d     = y_q;
    zero_d  = zero_q;
    red_d   = red_q;
    cnt_d   = cnt_q;
    // A load wins over a drain, so a simultaneous fire keeps valid high.
    if (in_fire) begin
      valid_d = 1'b1;
      y_d     = y_c;
      zero_d  = (y_c == '0);
      red_d   = red_c;
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
    if (out_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      zero_q  <= 1'b0;
      red_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      red_q   <= red_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign red       = red_q;
  assign txn_count = cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: directed vectors, queue-based output checking.
module tb_logic_gate_pipe;

  typedef struct packed {
    logic [7:0] y;
    logic       zero;
    logic       red;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, y;
  logic [2:0] op;
  logic       zero, red;
  logic [3:0] txn_count;

  logic        w_in_valid, w_out_ready;
  logic [2:0]  w_op;
  logic [0:0]  a1, b1, y1;
  logic        rdy1, ov1, zero1, red1;
  logic [3:0]  cnt1;
  logic [31:0] a32, b32, y32;
  logic        rdy32, ov32, zero32, red32;
  logic [3:0]  cnt32;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .red(red), .txn_count(txn_count)
  );

  logic_gate_pipe #(.WIDTH(1), .CNT_W(4)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(rdy1),
    .a(a1), .b(b1), .op(w_op), .out_valid(ov1), .out_ready(w_out_ready),
    .y(y1), .zero(zero1), .red(red1), .txn_count(cnt1)
  );

  logic_gate_pipe #(.WIDTH(32), .CNT_W(4)) dut_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(rdy32),
    .a(a32), .b(b32), .op(w_op), .out_valid(ov32), .out_ready(w_out_ready),
    .y(y32), .zero(zero32), .red(red32), .txn_count(cnt32)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake consumes the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected: got y=%h with no expected entry", y);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_y", 32'(y), 32'(e.y));
        chk("mon_zero", 32'(zero), 32'(e.zero));
        chk("mon_red", 32'(red), 32'(e.red));
      end
    end
  end

  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top,
                      input logic [7:0] ey, input logic er);
    exp_t e;
    a = ta; b = tb; op = top; in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e.y = ey; e.zero = (ey == 8'h00); e.red = er;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got in_ready=0 for 20 cycles expected 1");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [7:0] vy  [8] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, 8'hF0};
  logic       vred[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_op = 3'd0; a1 = '0; b1 = '0; a32 = '0; b32 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_txn", 32'(txn_count), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // Width sweep: NAND of all-ones at WIDTH=1 and WIDTH=32.
    w_op = 3'd3; a1 = 1'b1; b1 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;
    w_in_valid = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    chk("w1_y", 32'(y1), 32'h0);
    chk("w1_zero", 32'(zero1), 32'h1);
    chk("w1_red", 32'(red1), 32'h0);
    chk("w1_valid", 32'(ov1), 32'h1);
    chk("w32_y", y32, 32'h0);
    chk("w32_zero", 32'(zero32), 32'h1);
    chk("w32_red", 32'(red32), 32'h0);
    chk("w32_valid", 32'(ov32), 32'h1);

    // Reset with a result pending under backpressure.
    out_ready = 1'b0;
    send(8'hF0, 8'hCC, 3'd0, 8'hC0, 1'b0);
    chk("pend_y", 32'(y), 32'hC0);
    chk("pend_valid", 32'(out_valid), 32'h1);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("async_rst_y", 32'(y), 32'h0);
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_txn", 32'(txn_count), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);

    // All eight ops back to back.
    for (int i = 0; i < 8; i++) send(8'hF0, 8'hCC, 3'(i), vy[i], vred[i]);
    drain();
    chk("ops_txn", 32'(txn_count), 32'h8);

    // Backpressure, then simultaneous output and input fire.
    out_ready = 1'b0;
    send(8'hAA, 8'h55, 3'd0, 8'h00, 1'b0);
    a = 8'h5A; b = 8'h00; op = 3'd7; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_y", 32'(y), 32'h00);
      chk("bp_zero", 32'(zero), 32'h1);
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("sim_in_ready", 32'(in_ready), 32'h1);
    begin
      exp_t e;
      e.y = 8'h5A; e.zero = 1'b0; e.red = 1'b1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("sim_y", 32'(y), 32'h5A);
    chk("sim_valid", 32'(out_valid), 32'h1);
    chk("sim_txn", 32'(txn_count), 32'h9);
    @(posedge clk); #1;
    chk("drain_txn", 32'(txn_count), 32'hA);
    chk("drain_valid", 32'(out_valid), 32'h0);

    // Counter wrap from a fresh reset.
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) send(8'h81, 8'h00, 3'd1, 8'h81, 1'b1);
    drain();
    chk("wrap16_txn", 32'(txn_count), 32'h0);
    send(8'h81, 8'h00, 3'd1, 8'h81, 1'b1);
    drain();
    chk("wrap17_txn", 32'(txn_count), 32'h1);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
